// File: rtl/fp_mult_sched_pkg.sv
// Shared definitions for the FP multiplier scheduler: format selectors,
// requester ids, the in-flight tag type and the round-robin pick.
`ifndef FP_MULT_SCHED_PKG_SV
`define FP_MULT_SCHED_PKG_SV

`define FP16 0
`define FP32 1
`define FP64 2
`define GET_EXP_LEN(f)      (((f) == `FP64) ? 11 : (((f) == `FP16) ? 5 : 8))
`define GET_MANTISSA_LEN(f) (((f) == `FP64) ? 52 : (((f) == `FP16) ? 10 : 23))

package fp_mult_sched_pkg;

   localparam logic REQ_A = 1'b0;
   localparam logic REQ_B = 1'b1;

   typedef struct packed {
      logic vld;
      logic id;
   } tag_t;

   // The requester that did not win last time takes a contended slot.
   function automatic logic rr_winner(input logic a_v, input logic b_v, input logic last);
      if (a_v && b_v) begin
         return ~last;
      end
      if (b_v) begin
         return REQ_B;
      end
      return REQ_A;
   endfunction

endpackage

`endif

// File: rtl/fp_mult_tag_pipe.sv
// Ownership tags travelling alongside the multiplier stages; entry LAT-1 is
// the head and lines up with the datapath result.
module fp_mult_tag_pipe
   import fp_mult_sched_pkg::*;
#(
   parameter int unsigned LAT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic flush,
   input  logic en,
   input  logic in_vld,
   input  logic in_id,
   output logic head_vld,
   output logic head_id
);

   tag_t [LAT-1:0] tag_q;
   tag_t [LAT-1:0] tag_d;
   tag_t           in_tag;

   assign in_tag = '{vld: in_vld, id: in_id};

   generate
      if (LAT == 1) begin : g_single
         always_comb tag_d = in_tag;
      end else begin : g_shift
         always_comb tag_d = {tag_q[LAT-2:0], in_tag};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         tag_q <= '0;
      end else if (en) begin
         tag_q <= tag_d;
      end
   end

   assign head_vld = tag_q[LAT-1].vld;
   assign head_id  = tag_q[LAT-1].id;

endmodule

// File: rtl/fp_mult_sched.sv
// Round-robin sharing of one fixed-latency FP multiplier between requesters
// A and B, with result steering and a global stall on consumer back-pressure.
module fp_mult_sched
   import fp_mult_sched_pkg::*;
#(
   parameter  int unsigned data_format = `FP32,
   parameter  int unsigned LAT         = 4,
   localparam int unsigned W  = 1 + `GET_EXP_LEN(data_format) + `GET_MANTISSA_LEN(data_format),
   localparam int unsigned CW = $clog2(LAT + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          a_valid,
   input  logic          b_valid,
   output logic          a_ready,
   output logic          b_ready,
   input  logic [W-1:0]  a_op1,
   input  logic [W-1:0]  a_op2,
   input  logic [W-1:0]  b_op1,
   input  logic [W-1:0]  b_op2,
   output logic          a_res_valid,
   output logic          b_res_valid,
   input  logic          a_res_ready,
   input  logic          b_res_ready,
   output logic [W-1:0]  a_res,
   output logic [W-1:0]  b_res,
   output logic          dp_in_valid,
   output logic [W-1:0]  dp_op1,
   output logic [W-1:0]  dp_op2,
   output logic          dp_en,
   input  logic [W-1:0]  dp_result,
   output logic [CW-1:0] inflight
);

   logic          last_q;
   logic          last_d;
   logic [CW-1:0] inflight_q;
   logic [CW-1:0] inflight_d;
   logic          head_vld;
   logic          head_id;
   logic          owner_rdy;
   logic          winner;
   logic          issue;
   logic          accept;

   // Stall, arbitration and steering; reset forces the handshakes quiet.
   always_comb begin
      owner_rdy   = (head_id == REQ_B) ? b_res_ready : a_res_ready;
      dp_en       = rst | ~(head_vld & ~owner_rdy);
      winner      = rr_winner(a_valid, b_valid, last_q);
      issue       = dp_en & ~flush & ~rst & (a_valid | b_valid);
      accept      = ~rst & head_vld & owner_rdy;
      a_ready     = issue & (winner == REQ_A);
      b_ready     = issue & (winner == REQ_B);
      dp_in_valid = issue;
      a_res_valid = ~rst & head_vld & (head_id == REQ_A);
      b_res_valid = ~rst & head_vld & (head_id == REQ_B);
      dp_op1      = (winner == REQ_B) ? b_op1 : a_op1;
      dp_op2      = (winner == REQ_B) ? b_op2 : a_op2;
   end

   assign a_res = dp_result;
   assign b_res = dp_result;

   always_comb begin
      last_d     = last_q;
      inflight_d = inflight_q;
      if (issue) begin
         last_d = winner;
      end
      if (flush) begin
         inflight_d = '0;
      end else begin
         inflight_d = inflight_q + CW'(issue) - CW'(accept);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q     <= REQ_B;
         inflight_q <= '0;
      end else begin
         last_q     <= last_d;
         inflight_q <= inflight_d;
      end
   end

   assign inflight = inflight_q;

   fp_mult_tag_pipe #(.LAT(LAT)) u_tags (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .en       (dp_en),
      .in_vld   (issue),
      .in_id    (winner),
      .head_vld (head_vld),
      .head_id  (head_id)
   );

endmodule

// File: tb/tb_fp_mult_sched.sv
// Directed bench for fp_mult_sched with a behavioural multiplier pipe,
// a cycle model of the scheduler and per-owner result scoreboards.
module tb_fp_mult_sched;

   localparam int LAT = 4;
   localparam int W   = 32;

   logic          clk = 1'b0;
   logic          rst, flush, a_valid, b_valid, a_res_ready, b_res_ready;
   logic [W-1:0]  a_op1, a_op2, b_op1, b_op2;
   logic          a_ready, b_ready, a_res_valid, b_res_valid, dp_in_valid, dp_en;
   logic [W-1:0]  a_res, b_res, dp_op1, dp_op2, dp_result;
   logic [2:0]    inflight;

   fp_mult_sched #(.LAT(LAT)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .a_valid(a_valid), .b_valid(b_valid), .a_ready(a_ready), .b_ready(b_ready),
      .a_op1(a_op1), .a_op2(a_op2), .b_op1(b_op1), .b_op2(b_op2),
      .a_res_valid(a_res_valid), .b_res_valid(b_res_valid),
      .a_res_ready(a_res_ready), .b_res_ready(b_res_ready),
      .a_res(a_res), .b_res(b_res),
      .dp_in_valid(dp_in_valid), .dp_op1(dp_op1), .dp_op2(dp_op2),
      .dp_en(dp_en), .dp_result(dp_result), .inflight(inflight)
   );

   always #5 clk = ~clk;

   // Normal-operand FP32 multiply with truncation.
   function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
      logic [47:0] p;
      logic [22:0] m;
      int          e;
      if (x[30:23] == 8'd0 || y[30:23] == 8'd0) return {x[31] ^ y[31], 31'd0};
      p = {24'd0, 1'b1, x[22:0]} * {24'd0, 1'b1, y[22:0]};
      e = int'(x[30:23]) + int'(y[30:23]) - 127;
      if (p[47]) begin
         m = p[46:24];
         e++;
      end else begin
         m = p[45:23];
      end
      return {x[31] ^ y[31], e[7:0], m};
   endfunction

   logic [W-1:0] dpp [LAT];
   always @(posedge clk) begin
      if (dp_en) begin
         dpp[0] <= fp_mul(dp_op1, dp_op2);
         for (int i = 1; i < LAT; i++) dpp[i] <= dpp[i-1];
      end
   end
   assign dp_result = dpp[LAT-1];

   int           n_checks = 0;
   int           n_fail   = 0;
   logic [W-1:0] q_a [$];
   logic [W-1:0] q_b [$];
   logic         m_vld [LAT];
   logic         m_id  [LAT];
   logic         m_last;
   int           m_inflight;
   logic         e_issue, e_win, e_en, e_arv, e_brv, e_acc;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_ops();
      a_op1 = {1'b0, 8'(8'd124 + 8'($urandom_range(0, 6))), 23'($urandom)};
      a_op2 = {1'b1, 8'(8'd124 + 8'($urandom_range(0, 6))), 23'($urandom)};
      b_op1 = {1'b0, 8'(8'd120 + 8'($urandom_range(0, 9))), 23'($urandom)};
      b_op2 = {1'b0, 8'(8'd126 + 8'($urandom_range(0, 3))), 23'($urandom)};
   endtask

   // Mid-cycle: predict every output from the model, check it, run the scoreboard.
   task automatic sample();
      logic hv, hid, ordy;
      logic [W-1:0] ev;
      @(negedge clk);
      hv      = m_vld[LAT-1];
      hid     = m_id[LAT-1];
      ordy    = hid ? b_res_ready : a_res_ready;
      e_en    = rst || !(hv && !ordy);
      e_win   = (a_valid && b_valid) ? !m_last : b_valid;
      e_issue = e_en && !flush && !rst && (a_valid || b_valid);
      e_arv   = !rst && hv && !hid;
      e_brv   = !rst && hv && hid;
      e_acc   = (e_arv && a_res_ready) || (e_brv && b_res_ready);
      chk("dp_en",       64'(dp_en),       64'(e_en));
      chk("a_ready",     64'(a_ready),     64'(e_issue && !e_win));
      chk("b_ready",     64'(b_ready),     64'(e_issue && e_win));
      chk("dp_in_valid", 64'(dp_in_valid), 64'(e_issue));
      chk("a_res_valid", 64'(a_res_valid), 64'(e_arv));
      chk("b_res_valid", 64'(b_res_valid), 64'(e_brv));
      chk("inflight",    64'(inflight),    64'(m_inflight));
      if (e_issue) begin
         chk("dp_op1", 64'(dp_op1), 64'(e_win ? b_op1 : a_op1));
         chk("dp_op2", 64'(dp_op2), 64'(e_win ? b_op2 : a_op2));
         if (e_win) q_b.push_back(fp_mul(b_op1, b_op2));
         else       q_a.push_back(fp_mul(a_op1, a_op2));
      end
      if (e_arv && a_res_ready) begin
         chk("a_res_pending", 64'(q_a.size() != 0), 64'd1);
         if (q_a.size() != 0) begin
            ev = q_a.pop_front();
            chk("a_res", 64'(a_res), 64'(ev));
         end
      end
      if (e_brv && b_res_ready) begin
         chk("b_res_pending", 64'(q_b.size() != 0), 64'd1);
         if (q_b.size() != 0) begin
            ev = q_b.pop_front();
            chk("b_res", 64'(b_res), 64'(ev));
         end
      end
   endtask

   // Clock edge: advance the model with the values sampled this cycle.
   task automatic adv();
      @(posedge clk);
      if (rst || flush) begin
         for (int i = 0; i < LAT; i++) m_vld[i] = 1'b0;
         m_inflight = 0;
         q_a.delete();
         q_b.delete();
         if (rst) m_last = 1'b1;
      end else begin
         if (e_en) begin
            for (int i = LAT - 1; i > 0; i--) begin
               m_vld[i] = m_vld[i-1];
               m_id[i]  = m_id[i-1];
            end
            m_vld[0] = e_issue;
            m_id[0]  = e_win;
         end
         m_inflight += int'(e_issue) - int'(e_acc);
         if (e_issue) m_last = e_win;
      end
      #1;
   endtask

   task automatic drain(input string tag);
      a_valid = 1'b0;
      b_valid = 1'b0;
      a_res_ready = 1'b1;
      b_res_ready = 1'b1;
      for (int k = 0; k < 4 * LAT && m_inflight != 0; k++) begin
         sample();
         adv();
      end
      chk({tag, "_pending_results"}, 64'(q_a.size() + q_b.size()), 64'd0);
      chk({tag, "_inflight_zero"}, 64'(inflight), 64'd0);
   endtask

   initial begin
      int   peak;
      logic found;
      logic [W-1:0] held;

      rst = 1'b1; flush = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
      a_res_ready = 1'b1; b_res_ready = 1'b1;
      set_ops();
      for (int i = 0; i < LAT; i++) begin
         m_vld[i] = 1'b0;
         m_id[i]  = 1'b0;
      end
      m_last = 1'b1;
      m_inflight = 0;
      e_issue = 1'b0; e_win = 1'b0; e_en = 1'b1; e_arv = 1'b0; e_brv = 1'b0; e_acc = 1'b0;
      @(posedge clk); #1;
      sample();
      chk("rst_dp_en", 64'(dp_en), 64'd1);
      adv();
      rst = 1'b0;

      // Contention from reset: A first, then alternating.
      a_valid = 1'b1; b_valid = 1'b1;
      peak = 0;
      for (int i = 0; i < 6; i++) begin
         set_ops();
         sample();
         chk("cont_grant_a", 64'(a_ready), 64'(i % 2 == 0));
         chk("cont_grant_b", 64'(b_ready), 64'(i % 2 == 1));
         if (int'(inflight) > peak) peak = int'(inflight);
         adv();
      end
      chk("cont_peak", 64'(peak), 64'd4);
      drain("cont");

      // Single op from A.
      a_op1 = 32'h3FC00000; a_op2 = 32'h40000000; a_valid = 1'b1;
      sample();
      chk("single_a_ready", 64'(a_ready), 64'd1);
      chk("single_dp_in_valid", 64'(dp_in_valid), 64'd1);
      adv();
      a_valid = 1'b0;
      for (int k = 1; k <= LAT; k++) begin
         sample();
         chk("single_a_res_valid", 64'(a_res_valid), 64'(k == LAT));
         chk("single_b_res_valid", 64'(b_res_valid), 64'd0);
         if (k == LAT) chk("single_a_res", 64'(a_res), 64'h40400000);
         adv();
      end

      // Back-pressure on a B-owned head.
      set_ops();
      b_valid = 1'b1;
      sample();
      adv();
      b_valid = 1'b0;
      b_res_ready = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 3 * LAT; k++) begin
         sample();
         if (b_res_valid) begin
            found = 1'b1;
            break;
         end
         adv();
      end
      chk("bp_head_seen", 64'(found), 64'd1);
      held = b_res;
      chk("bp_stall0_dp_en", 64'(dp_en), 64'd0);
      adv();
      a_valid = 1'b1;
      for (int k = 1; k < 3; k++) begin
         sample();
         chk("bp_stall_dp_en", 64'(dp_en), 64'd0);
         chk("bp_stall_no_issue", 64'(a_ready), 64'd0);
         chk("bp_b_res_stable", 64'(b_res), 64'(held));
         adv();
      end
      b_res_ready = 1'b1;
      sample();
      chk("bp_resume_accept_issue", 64'(a_ready && b_res_valid), 64'd1);
      adv();
      drain("bp");

      // Full pipe, head accepted while A issues.
      a_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         set_ops();
         sample();
         if (i == 5) begin
            chk("simul_a_ready", 64'(a_ready), 64'd1);
            chk("simul_a_res_valid", 64'(a_res_valid), 64'd1);
            chk("simul_inflight", 64'(inflight), 64'd4);
         end
         adv();
      end
      drain("simul");

      // Flush with three operations in flight.
      a_valid = 1'b1; b_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_ops();
         sample();
         adv();
      end
      a_valid = 1'b0; b_valid = 1'b0; flush = 1'b1;
      sample();
      chk("flush_inflight_before", 64'(inflight), 64'd3);
      adv();
      flush = 1'b0;
      set_ops();
      a_valid = 1'b1;
      sample();
      chk("flush_inflight_after", 64'(inflight), 64'd0);
      chk("flush_no_a_res", 64'(a_res_valid), 64'd0);
      chk("flush_no_b_res", 64'(b_res_valid), 64'd0);
      chk("flush_reissue", 64'(a_ready), 64'd1);
      adv();
      drain("flush");

      // Reset in the middle of a full pipe.
      a_valid = 1'b1; b_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         set_ops();
         sample();
         adv();
      end
      rst = 1'b1;
      sample();
      chk("mid_rst_a_ready", 64'(a_ready), 64'd0);
      chk("mid_rst_b_ready", 64'(b_ready), 64'd0);
      chk("mid_rst_a_res_valid", 64'(a_res_valid), 64'd0);
      chk("mid_rst_b_res_valid", 64'(b_res_valid), 64'd0);
      chk("mid_rst_dp_in_valid", 64'(dp_in_valid), 64'd0);
      chk("mid_rst_dp_en", 64'(dp_en), 64'd1);
      adv();
      rst = 1'b0;
      set_ops();
      sample();
      chk("post_rst_inflight", 64'(inflight), 64'd0);
      chk("post_rst_grant_a", 64'(a_ready), 64'd1);
      chk("post_rst_no_grant_b", 64'(b_ready), 64'd0);
      adv();
      drain("post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
